// File: rtl/rc_axi_rdata_drv_pkg.sv
// Shared types and helpers for the RC AXI R-channel driver.
// Completion header layout (128 bits, DW0 in [31:0]):
//   DW0: [31:24] fmt/type, [23] T9, [19] T8, [14] EP, [9:0] length (DW)
//   DW1: [47:45] status, [43:32] byte count
//   DW2: [79:72] tag[7:0]
package rc_axi_rdata_drv_pkg;

    localparam int unsigned PIPE_DATA_WIDTH = 256;
    localparam int unsigned CPL_HDR_WIDTH   = 128;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        CplSc  = 3'b000,
        CplUr  = 3'b001,
        CplCrs = 3'b010,
        CplCa  = 3'b100
    } cpl_status_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StErrb
    } rdrv_state_t;

    function automatic logic [9:0] get_tag_from_cpl_hdr(input logic [CPL_HDR_WIDTH-1:0] hdr);
        return {hdr[23], hdr[19], hdr[79:72]};
    endfunction

    // Length field of 0 encodes 1024 DW.
    function automatic logic [10:0] get_len_dw_from_cpl_hdr(
        input logic [CPL_HDR_WIDTH-1:0] hdr
    );
        return {(hdr[9:0] == 10'd0), hdr[9:0]};
    endfunction

    // Byte count of 0 encodes 4096 bytes.
    function automatic logic [12:0] get_bc_from_cpl_hdr(input logic [CPL_HDR_WIDTH-1:0] hdr);
        return {(hdr[43:32] == 12'd0), hdr[43:32]};
    endfunction

    function automatic cpl_status_t get_cpl_status_from_cpl_hdr(
        input logic [CPL_HDR_WIDTH-1:0] hdr
    );
        return cpl_status_t'(hdr[47:45]);
    endfunction

    function automatic logic get_ep_from_hdr(input logic [CPL_HDR_WIDTH-1:0] hdr);
        return hdr[14];
    endfunction

endpackage

// File: rtl/rc_axi_rdata_drv_skid.sv
// Two-entry valid/ready skid buffer. Outputs come straight from storage, so they stay
// stable while out_valid_o && !out_ready_i. Push and pop in the same cycle never bubble.
module rc_axi_rdata_drv_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // Storage, pointers and occupancy; async reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/rc_axi_rdata_drv.sv
// AXI4 R-channel driver: pops completion headers/payload from show-ahead FIFOs and
// streams R beats through a 2-entry skid buffer. rlast only on the final completion
// of a split request. Optional feature macro: RC_POISON_EN (poisoned completions
// return SLVERR on every beat).
module rc_axi_rdata_drv
    import rc_axi_rdata_drv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned TAG_WIDTH  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hdr_empty_i,
    input  logic [CPL_HDR_WIDTH-1:0] hdr_data_i,
    output logic                     hdr_rden_o,
    input  logic                     pay_empty_i,
    input  logic [DATA_WIDTH-1:0]    pay_data_i,
    input  logic                     pay_last_i,
    output logic                     pay_rden_o,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [DATA_WIDTH-1:0]    r_data_o,
    output logic [ID_WIDTH-1:0]      r_id_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_last_o,
    output logic                     err_len_o,
    output logic                     busy_o
);

    localparam int unsigned SkidW     = DATA_WIDTH + ID_WIDTH + 3;
    localparam int unsigned DwPerBeat = DATA_WIDTH / 32;
    localparam int unsigned BeatShift = $clog2(DwPerBeat);

    rdrv_state_t          state_q;
    logic                 run_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [10:0]          len_dw_q;
    logic [12:0]          bc_q;
    logic [11:0]          beat_cnt_q;
    logic                 err_len_q;

    logic [11:0]          exp_beats;
    logic                 final_cpl;
    logic [ID_WIDTH-1:0]  rid;
    logic [1:0]           data_resp;

    logic                 skid_in_valid;
    logic                 skid_in_ready;
    logic [SkidW-1:0]     skid_in_data;
    logic                 skid_out_valid;
    logic [SkidW-1:0]     skid_out_data;

    logic                 unused_bits;

`ifdef RC_POISON_EN
    logic ep_q;
    assign data_resp = ep_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
    assign data_resp = AXI_RESP_OKAY;
`endif

    assign exp_beats   = 12'((12'(len_dw_q) + 12'(DwPerBeat - 1)) >> BeatShift);
    // Earlier pieces of a split completion carry a byte count beyond their own payload.
    assign final_cpl   = (bc_q <= {len_dw_q, 2'b00});
    assign rid         = tag_q[ID_WIDTH-1:0];
    assign unused_bits = ^{hdr_data_i, tag_q};

    // FIFO pop strobes and skid push selection.
    always_comb begin
        hdr_rden_o    = 1'b0;
        pay_rden_o    = 1'b0;
        skid_in_valid = 1'b0;
        skid_in_data  = '0;
        case (state_q)
            StIdle: begin
                hdr_rden_o = run_q && !hdr_empty_i;
            end
            StData: begin
                pay_rden_o    = !pay_empty_i && skid_in_ready;
                skid_in_valid = pay_rden_o;
                skid_in_data  = {pay_data_i, rid, data_resp, final_cpl && pay_last_i};
            end
            StErrb: begin
                skid_in_valid = 1'b1;
                skid_in_data  = {{DATA_WIDTH{1'b0}}, rid, AXI_RESP_SLVERR, 1'b1};
            end
            default: ;
        endcase
    end

    // Completion FSM: header capture, beat counting and length check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            tag_q      <= '0;
            len_dw_q   <= '0;
            bc_q       <= '0;
            beat_cnt_q <= '0;
            err_len_q  <= 1'b0;
`ifdef RC_POISON_EN
            ep_q       <= 1'b0;
`endif
        end else begin
            // Hold off header pops for one cycle after reset release.
            run_q     <= 1'b1;
            err_len_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (hdr_rden_o) begin
                        tag_q      <= TAG_WIDTH'(get_tag_from_cpl_hdr(hdr_data_i));
                        len_dw_q   <= get_len_dw_from_cpl_hdr(hdr_data_i);
                        bc_q       <= get_bc_from_cpl_hdr(hdr_data_i);
                        beat_cnt_q <= '0;
`ifdef RC_POISON_EN
                        ep_q       <= get_ep_from_hdr(hdr_data_i);
`endif
                        state_q    <= (get_cpl_status_from_cpl_hdr(hdr_data_i) == CplSc) ?
                                      StData : StErrb;
                    end
                end
                StData: begin
                    if (pay_rden_o) begin
                        if (pay_last_i) begin
                            err_len_q  <= ((beat_cnt_q + 12'd1) != exp_beats);
                            beat_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 12'd1;
                        end
                    end
                end
                StErrb: begin
                    if (skid_in_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    rc_axi_rdata_drv_skid #(
        .WIDTH (SkidW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (skid_in_valid),
        .in_ready_o  (skid_in_ready),
        .in_data_i   (skid_in_data),
        .out_valid_o (skid_out_valid),
        .out_ready_i (r_ready_i),
        .out_data_o  (skid_out_data)
    );

    assign r_valid_o = skid_out_valid;
    assign {r_data_o, r_id_o, r_resp_o, r_last_o} = skid_out_data;
    assign err_len_o = err_len_q;
    assign busy_o    = (state_q != StIdle) || skid_out_valid;

endmodule

// File: tb/tb_rc_axi_rdata_drv.sv
// Directed bench for rc_axi_rdata_drv (DATA_WIDTH=256, ID_WIDTH=8).
module tb_rc_axi_rdata_drv;

    localparam int DW  = 256;
    localparam int IDW = 8;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } pay_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           hdr_empty_i;
    logic [127:0]   hdr_data_i;
    logic           hdr_rden_o;
    logic           pay_empty_i;
    logic [DW-1:0]  pay_data_i;
    logic           pay_last_i;
    logic           pay_rden_o;
    logic           r_valid_o;
    logic           r_ready_i;
    logic [DW-1:0]  r_data_o;
    logic [IDW-1:0] r_id_o;
    logic [1:0]     r_resp_o;
    logic           r_last_o;
    logic           err_len_o;
    logic           busy_o;

    logic [127:0] hdr_q [$];
    pay_t         pay_q [$];
    beat_t        out_q [$];
    int           hpop_cyc [$];

    int    checks = 0;
    int    failures = 0;
    int    err_cnt = 0;
    int    pay_pops = 0;
    int    stab_err = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    logic  prev_stall = 1'b0;
    beat_t stall_b;

    always #5 clk = ~clk;

    rc_axi_rdata_drv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hdr_empty_i (hdr_empty_i),
        .hdr_data_i  (hdr_data_i),
        .hdr_rden_o  (hdr_rden_o),
        .pay_empty_i (pay_empty_i),
        .pay_data_i  (pay_data_i),
        .pay_last_i  (pay_last_i),
        .pay_rden_o  (pay_rden_o),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready_i),
        .r_data_o    (r_data_o),
        .r_id_o      (r_id_o),
        .r_resp_o    (r_resp_o),
        .r_last_o    (r_last_o),
        .err_len_o   (err_len_o),
        .busy_o      (busy_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: accepted beats, error pulses, pops and stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (r_valid_o && r_ready_i) out_q.push_back({r_data_o, r_id_o, r_resp_o, r_last_o});
            if (err_len_o) err_cnt <= err_cnt + 1;
            if (pay_rden_o) pay_pops <= pay_pops + 1;
            if (hdr_rden_o) hpop_cyc.push_back(cyc);
            if (prev_stall && (r_valid_o !== 1'b1 ||
                               {r_data_o, r_id_o, r_resp_o, r_last_o} !== stall_b))
                stab_err <= stab_err + 1;
        end
        prev_stall <= rst_n && r_valid_o && !r_ready_i;
        stall_b    <= {r_data_o, r_id_o, r_resp_o, r_last_o};
    end

    function automatic logic [127:0] mk_hdr(input logic [9:0] tag, input logic [9:0] len,
                                            input logic [11:0] bc, input logic [2:0] st,
                                            input logic ep);
        logic [127:0] h;
        h = '0;
        h[31:24] = 8'h4A;
        h[23]    = tag[9];
        h[19]    = tag[8];
        h[14]    = ep;
        h[9:0]   = len;
        h[47:45] = st;
        h[43:32] = bc;
        h[79:72] = tag[7:0];
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int k);
        return {8{32'hD000_0000 | 32'(k)}};
    endfunction

    task automatic drive_inputs();
        hdr_empty_i = (hdr_q.size() == 0);
        hdr_data_i  = (hdr_q.size() != 0) ? hdr_q[0] : '0;
        pay_empty_i = (pay_q.size() == 0);
        pay_data_i  = (pay_q.size() != 0) ? pay_q[0].d : '0;
        pay_last_i  = (pay_q.size() != 0) ? pay_q[0].l : 1'b0;
    endtask

    // One clock: sample pops mid-cycle, retire them after the edge, then redrive inputs.
    task automatic tick();
        logic hp;
        logic pp;
        @(negedge clk);
        hp = hdr_rden_o;
        pp = pay_rden_o;
        @(posedge clk);
        #1;
        if (hp && hdr_q.size() > 0) hdr_q.delete(0);
        if (pp && pay_q.size() > 0) pay_q.delete(0);
        case (rdy_mode)
            0:       r_ready_i = 1'b1;
            1:       r_ready_i = ~r_ready_i;
            default: r_ready_i = 1'b0;
        endcase
        drive_inputs();
        #1;
    endtask

    task automatic wait_beats(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_q.size() >= target) break;
            tick();
        end
        if (out_q.size() >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r_ready_i = 1'b1;
        drive_inputs();
        repeat (3) tick();
        checks++;
        if (r_valid_o !== 1'b0 || busy_o !== 1'b0 || err_len_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got valid=%b busy=%b err=%b exp 0 0 0",
                     r_valid_o, busy_o, err_len_o);
        end
        checks++;
        if (hdr_rden_o !== 1'b0 || pay_rden_o !== 1'b0 || r_last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_rden got hdr=%b pay=%b last=%b exp 0 0 0",
                     hdr_rden_o, pay_rden_o, r_last_o);
        end
        checks++;
        if (r_data_o !== '0 || r_id_o !== '0 || r_resp_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_data got data=%h id=%h resp=%b exp 0", r_data_o, r_id_o, r_resp_o);
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single();
        int    s;
        bit    ok;
        beat_t e;
        s = out_q.size();
        hdr_q.push_back(mk_hdr(10'h005, 10'd16, 12'd64, 3'b000, 1'b0));
        pay_q.push_back({mk_data(1), 1'b0});
        pay_q.push_back({mk_data(2), 1'b1});
        drive_inputs();
        #1;
        checks++;
        if (hdr_rden_o !== 1'b1) begin
            failures++;
            $display("FAIL single_hdr_pop got=%b exp=1", hdr_rden_o);
        end
        tick();
        checks++;
        if (pay_rden_o !== 1'b1 || r_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_lat_n1 got pay_rden=%b r_valid=%b exp 1 0", pay_rden_o, r_valid_o);
        end
        tick();
        checks++;
        if (r_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL single_lat_n2 got r_valid=%b exp=1", r_valid_o);
        end
        wait_beats(s + 2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout got=%0d beats exp=2", out_q.size() - s);
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = {mk_data(k + 1), 8'h05, 2'b00, (k == 1)};
                checks++;
                if (out_q[s + k] !== e) begin
                    failures++;
                    $display("FAIL single_beat%0d got=%h exp=%h", k, out_q[s + k], e);
                end
            end
        end
        repeat (3) tick();
        checks++;
        if (busy_o !== 1'b0 || out_q.size() != s + 2) begin
            failures++;
            $display("FAIL single_idle got busy=%b beats=%0d exp 0 2", busy_o, out_q.size() - s);
        end
    endtask

    task automatic test_split();
        int    s;
        bit    ok;
        beat_t e;
        s = out_q.size();
        hdr_q.push_back(mk_hdr(10'h011, 10'd16, 12'd128, 3'b000, 1'b0));
        hdr_q.push_back(mk_hdr(10'h011, 10'd16, 12'd64, 3'b000, 1'b0));
        for (int k = 0; k < 4; k++) pay_q.push_back({mk_data(32'h20 + k), (k == 1 || k == 3)});
        drive_inputs();
        wait_beats(s + 4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL split_timeout got=%0d beats exp=4", out_q.size() - s);
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = {mk_data(32'h20 + k), 8'h11, 2'b00, (k == 3)};
                checks++;
                if (out_q[s + k] !== e) begin
                    failures++;
                    $display("FAIL split_beat%0d got=%h exp=%h", k, out_q[s + k], e);
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        int    s;
        int    st0;
        bit    ok;
        beat_t e;
        s = out_q.size();
        st0 = stab_err;
        rdy_mode = 1;
        hdr_q.push_back(mk_hdr(10'h022, 10'd64, 12'd256, 3'b000, 1'b0));
        for (int k = 0; k < 4; k++) pay_q.push_back({mk_data(32'h40 + k), 1'b0});
        drive_inputs();
        repeat (8) tick();
        // Payload FIFO runs dry mid-completion before the rest arrives.
        for (int k = 4; k < 8; k++) pay_q.push_back({mk_data(32'h40 + k), (k == 7)});
        drive_inputs();
        wait_beats(s + 8, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_timeout got=%0d beats exp=8", out_q.size() - s);
        end else begin
            for (int k = 0; k < 8; k++) begin
                e = {mk_data(32'h40 + k), 8'h22, 2'b00, (k == 7)};
                checks++;
                if (out_q[s + k] !== e) begin
                    failures++;
                    $display("FAIL bp_beat%0d got=%h exp=%h", k, out_q[s + k], e);
                end
            end
        end
        repeat (6) tick();
        checks++;
        if (out_q.size() != s + 8) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=8", out_q.size() - s);
        end
        checks++;
        if (stab_err != st0) begin
            failures++;
            $display("FAIL bp_stable got=%0d unstable stalls exp=0", stab_err - st0);
        end
        rdy_mode = 0;
        repeat (2) tick();
    endtask

    task automatic test_ur();
        int    s;
        int    p0;
        bit    ok;
        beat_t e;
        s = out_q.size();
        p0 = pay_pops;
        hdr_q.push_back(mk_hdr(10'h003, 10'd16, 12'd64, 3'b001, 1'b0));
        pay_q.push_back({mk_data(32'h99), 1'b1});
        drive_inputs();
        wait_beats(s + 1, ok);
        repeat (3) tick();
        e = {{DW{1'b0}}, 8'h03, 2'b10, 1'b1};
        checks++;
        if (!ok || out_q[s] !== e) begin
            failures++;
            $display("FAIL ur_beat got=%h exp=%h", ok ? out_q[s] : '0, e);
        end
        checks++;
        if (pay_pops != p0 || pay_q.size() != 1) begin
            failures++;
            $display("FAIL ur_no_pay_pop got pops=%0d left=%0d exp 0 1", pay_pops - p0, pay_q.size());
        end
        pay_q.delete();
        drive_inputs();
        tick();
    endtask

    task automatic test_len_err();
        int    s;
        int    e0;
        bit    ok;
        beat_t e;
        s = out_q.size();
        e0 = err_cnt;
        hdr_q.push_back(mk_hdr(10'h009, 10'd16, 12'd64, 3'b000, 1'b0));
        pay_q.push_back({mk_data(32'h50), 1'b1});
        drive_inputs();
        wait_beats(s + 1, ok);
        repeat (3) tick();
        e = {mk_data(32'h50), 8'h09, 2'b00, 1'b1};
        checks++;
        if (!ok || out_q[s] !== e) begin
            failures++;
            $display("FAIL lenerr_beat got=%h exp=%h", ok ? out_q[s] : '0, e);
        end
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL lenerr_pulse got=%0d pulses exp=1", err_cnt - e0);
        end
        hdr_q.push_back(mk_hdr(10'h00A, 10'd8, 12'd32, 3'b000, 1'b0));
        pay_q.push_back({mk_data(32'h51), 1'b1});
        drive_inputs();
        wait_beats(s + 2, ok);
        repeat (3) tick();
        e = {mk_data(32'h51), 8'h0A, 2'b00, 1'b1};
        checks++;
        if (!ok || out_q[s + 1] !== e || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL lenerr_next got=%h errs=%0d exp=%h errs=1",
                     ok ? out_q[s + 1] : '0, err_cnt - e0, e);
        end
    endtask

    task automatic test_poison();
        int         s;
        bit         ok;
        beat_t      e;
        logic [1:0] exp_resp;
`ifdef RC_POISON_EN
        exp_resp = 2'b10;
`else
        exp_resp = 2'b00;
`endif
        s = out_q.size();
        hdr_q.push_back(mk_hdr(10'h00C, 10'd8, 12'd32, 3'b000, 1'b1));
        pay_q.push_back({mk_data(32'h60), 1'b1});
        drive_inputs();
        wait_beats(s + 1, ok);
        repeat (2) tick();
        e = {mk_data(32'h60), 8'h0C, exp_resp, 1'b1};
        checks++;
        if (!ok || out_q[s] !== e) begin
            failures++;
            $display("FAIL poison_beat got=%h exp=%h", ok ? out_q[s] : '0, e);
        end
    endtask

    task automatic test_reset_midburst();
        bit ok;
        ok = 1'b0;
        rdy_mode = 2;
        hdr_q.push_back(mk_hdr(10'h00D, 10'd64, 12'd256, 3'b000, 1'b0));
        for (int k = 0; k < 8; k++) pay_q.push_back({mk_data(32'h70 + k), (k == 7)});
        drive_inputs();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (r_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_valid got r_valid=%b exp=1", r_valid_o);
        end
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (r_valid_o !== 1'b0 || busy_o !== 1'b0 || pay_rden_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_drop got valid=%b busy=%b pay_rden=%b exp 0 0 0",
                     r_valid_o, busy_o, pay_rden_o);
        end
        hdr_q.delete();
        pay_q.delete();
        drive_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int    s;
        int    h0;
        bit    ok;
        beat_t e;
        s = out_q.size();
        h0 = hpop_cyc.size();
        hdr_q.push_back(mk_hdr(10'h030, 10'd8, 12'd32, 3'b000, 1'b0));
        hdr_q.push_back(mk_hdr(10'h031, 10'd8, 12'd32, 3'b000, 1'b0));
        pay_q.push_back({mk_data(32'h80), 1'b1});
        pay_q.push_back({mk_data(32'h81), 1'b1});
        drive_inputs();
        wait_beats(s + 2, ok);
        repeat (2) tick();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout got=%0d beats exp=2", out_q.size() - s);
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = {mk_data(32'h80 + k), 8'h30 + 8'(k), 2'b00, 1'b1};
                checks++;
                if (out_q[s + k] !== e) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%h exp=%h", k, out_q[s + k], e);
                end
            end
        end
        checks++;
        if (hpop_cyc.size() != h0 + 2) begin
            failures++;
            $display("FAIL b2b_hdr_pops got=%0d exp=2", hpop_cyc.size() - h0);
        end else if (hpop_cyc[h0 + 1] - hpop_cyc[h0] != 2) begin
            failures++;
            $display("FAIL b2b_gap got=%0d exp=2", hpop_cyc[h0 + 1] - hpop_cyc[h0]);
        end
    endtask

    initial begin
        r_ready_i = 1'b1;
        drive_inputs();
        test_reset();
        test_single();
        test_split();
        test_backpressure();
        test_ur();
        test_len_err();
        test_poison();
        test_reset_midburst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
